// File: rtl/reservation_station.sv
// Reservation station for non-memory ops (ALU, branch, jump, LUI/AUIPC).
// Entries wait until both operands are valid. Late operands are captured
// from the ALU and LSB common data buses. At most one ready entry is issued
// to the ALU per cycle, chosen by a fixed lowest-index priority encoder.
// Optional feature macro: RS_PERF_EN adds issue / full-cycle counters.
module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4,
  localparam int RS_W   = $clog2(RS_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             ROB_clear,
  input  logic             Dis_flag,
  input  logic [RS_W-1:0]  Dis_put_idx,
  input  logic [5:0]       Dis_op,
  input  logic [31:0]      Dis_imm,
  input  logic [31:0]      Dis_PC,
  input  logic [ROB_W-1:0] Dis_ROB_idx,
  input  logic             Dis_R1,
  input  logic             Dis_R2,
  input  logic [31:0]      Dis_V1,
  input  logic [31:0]      Dis_V2,
  input  logic [31:0]      Dis_BTB_PC,
  input  logic             Dis_BTB_predict,
  input  logic             ALU_CDB_flag,
  input  logic [ROB_W-1:0] ALU_CDB_idx,
  input  logic [31:0]      ALU_CDB_val,
  input  logic             LSB_CDB_flag,
  input  logic [ROB_W-1:0] LSB_CDB_idx,
  input  logic [31:0]      LSB_CDB_val,
  output logic [RS_W-1:0]  RS_free_idx,
  output logic             RS_full,
  output logic             RS_ready_out,
  output logic [RS_W-1:0]  RS_ready_idx,
  output logic             ALU_flag,
  output logic [5:0]       ALU_op,
  output logic [31:0]      ALU_V1,
  output logic [31:0]      ALU_V2,
  output logic [31:0]      ALU_imm,
  output logic [31:0]      ALU_PC,
  output logic [ROB_W-1:0] ALU_ROB_idx,
  output logic [31:0]      ALU_BTB_PC,
  output logic             ALU_BTB_pred
`ifdef RS_PERF_EN
  ,
  output logic [31:0]      perf_issue_cnt,
  output logic [31:0]      perf_full_cnt
`endif
);

  // Per-entry state gathered into vectors/arrays for selection and issue.
  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic [5:0]         op_arr       [RS_SIZE];
  logic [31:0]        v1_arr       [RS_SIZE];
  logic [31:0]        v2_arr       [RS_SIZE];
  logic [31:0]        imm_arr      [RS_SIZE];
  logic [31:0]        pc_arr       [RS_SIZE];
  logic [31:0]        btb_pc_arr   [RS_SIZE];
  logic [ROB_W-1:0]   rob_idx_arr  [RS_SIZE];
  logic               btb_pred_arr [RS_SIZE];

  // Any state update needs reset released, the core enabled and no flush.
  logic upd_en;
  logic wr_en;
  logic issue_en;

  assign upd_en   = rst && rdy && !ROB_clear;
  assign wr_en    = upd_en && Dis_flag && !RS_full;
  assign issue_en = upd_en && RS_ready_out;

  // Operand 1 as it will be latched at dispatch, including same-cycle CDB capture.
  logic        fwd1_r;
  logic [31:0] fwd1_v;
  always_comb begin
    fwd1_r = Dis_R1;
    fwd1_v = Dis_V1;
    if (!Dis_R1) begin
      if (ALU_CDB_flag && (ALU_CDB_idx == Dis_V1[ROB_W-1:0])) begin
        fwd1_r = 1'b1;
        fwd1_v = ALU_CDB_val;
      end else if (LSB_CDB_flag && (LSB_CDB_idx == Dis_V1[ROB_W-1:0])) begin
        fwd1_r = 1'b1;
        fwd1_v = LSB_CDB_val;
      end
    end
  end

  // Operand 2 as it will be latched at dispatch, including same-cycle CDB capture.
  logic        fwd2_r;
  logic [31:0] fwd2_v;
  always_comb begin
    fwd2_r = Dis_R2;
    fwd2_v = Dis_V2;
    if (!Dis_R2) begin
      if (ALU_CDB_flag && (ALU_CDB_idx == Dis_V2[ROB_W-1:0])) begin
        fwd2_r = 1'b1;
        fwd2_v = ALU_CDB_val;
      end else if (LSB_CDB_flag && (LSB_CDB_idx == Dis_V2[ROB_W-1:0])) begin
        fwd2_r = 1'b1;
        fwd2_v = LSB_CDB_val;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
      logic             busy_reg;
      logic             r1_reg;
      logic             r2_reg;
      logic [31:0]      v1_reg;
      logic [31:0]      v2_reg;
      logic [5:0]       op_reg;
      logic [31:0]      imm_reg;
      logic [31:0]      pc_reg;
      logic [31:0]      btb_pc_reg;
      logic [ROB_W-1:0] rob_idx_reg;
      logic             btb_pred_reg;

      logic wr_hit;
      logic iss_hit;
      logic wake1_alu;
      logic wake1_lsb;
      logic wake2_alu;
      logic wake2_lsb;

      // A waiting operand holds its producer tag in the low bits of the value field.
      assign wr_hit    = wr_en && (Dis_put_idx == RS_W'(gi));
      assign iss_hit   = issue_en && (RS_ready_idx == RS_W'(gi));
      assign wake1_alu = upd_en && busy_reg && !r1_reg && ALU_CDB_flag &&
                         (ALU_CDB_idx == v1_reg[ROB_W-1:0]);
      assign wake1_lsb = upd_en && busy_reg && !r1_reg && LSB_CDB_flag &&
                         (LSB_CDB_idx == v1_reg[ROB_W-1:0]);
      assign wake2_alu = upd_en && busy_reg && !r2_reg && ALU_CDB_flag &&
                         (ALU_CDB_idx == v2_reg[ROB_W-1:0]);
      assign wake2_lsb = upd_en && busy_reg && !r2_reg && LSB_CDB_flag &&
                         (LSB_CDB_idx == v2_reg[ROB_W-1:0]);

      // Busy and operand-valid flags: write, issue release, wakeup, flush.
      always_ff @(posedge clk) begin
        if (!rst) begin
          busy_reg <= 1'b0;
          r1_reg   <= 1'b0;
          r2_reg   <= 1'b0;
        end else if (rdy) begin
          if (ROB_clear) begin
            busy_reg <= 1'b0;
          end else if (wr_hit) begin
            busy_reg <= 1'b1;
            r1_reg   <= fwd1_r;
            r2_reg   <= fwd2_r;
          end else begin
            if (iss_hit) busy_reg <= 1'b0;
            if (wake1_alu || wake1_lsb) r1_reg <= 1'b1;
            if (wake2_alu || wake2_lsb) r2_reg <= 1'b1;
          end
        end
      end

      // Payload fields; only meaningful while busy, so no reset is needed.
      always_ff @(posedge clk) begin
        if (wr_hit) begin
          op_reg       <= Dis_op;
          imm_reg      <= Dis_imm;
          pc_reg       <= Dis_PC;
          btb_pc_reg   <= Dis_BTB_PC;
          btb_pred_reg <= Dis_BTB_predict;
          rob_idx_reg  <= Dis_ROB_idx;
          v1_reg       <= fwd1_v;
          v2_reg       <= fwd2_v;
        end else begin
          if (wake1_alu)      v1_reg <= ALU_CDB_val;
          else if (wake1_lsb) v1_reg <= LSB_CDB_val;
          if (wake2_alu)      v2_reg <= ALU_CDB_val;
          else if (wake2_lsb) v2_reg <= LSB_CDB_val;
        end
      end

      assign busy_vec[gi]     = busy_reg;
      assign ready_vec[gi]    = busy_reg && r1_reg && r2_reg;
      assign op_arr[gi]       = op_reg;
      assign v1_arr[gi]       = v1_reg;
      assign v2_arr[gi]       = v2_reg;
      assign imm_arr[gi]      = imm_reg;
      assign pc_arr[gi]       = pc_reg;
      assign btb_pc_arr[gi]   = btb_pc_reg;
      assign rob_idx_arr[gi]  = rob_idx_reg;
      assign btb_pred_arr[gi] = btb_pred_reg;
    end
  endgenerate

  assign RS_full      = &busy_vec;
  assign RS_ready_out = |ready_vec;

  // Lowest-index free slot and lowest-index ready entry (0 when none).
  always_comb begin
    RS_free_idx  = '0;
    RS_ready_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_vec[i])  RS_free_idx  = RS_W'(i);
      if (ready_vec[i])  RS_ready_idx = RS_W'(i);
    end
  end

  // Issue register: one-cycle ALU_flag pulse, payload holds when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ALU_flag     <= 1'b0;
      ALU_op       <= '0;
      ALU_V1       <= '0;
      ALU_V2       <= '0;
      ALU_imm      <= '0;
      ALU_PC       <= '0;
      ALU_ROB_idx  <= '0;
      ALU_BTB_PC   <= '0;
      ALU_BTB_pred <= 1'b0;
    end else begin
      ALU_flag <= issue_en;
      if (issue_en) begin
        ALU_op       <= op_arr[RS_ready_idx];
        ALU_V1       <= v1_arr[RS_ready_idx];
        ALU_V2       <= v2_arr[RS_ready_idx];
        ALU_imm      <= imm_arr[RS_ready_idx];
        ALU_PC       <= pc_arr[RS_ready_idx];
        ALU_ROB_idx  <= rob_idx_arr[RS_ready_idx];
        ALU_BTB_PC   <= btb_pc_arr[RS_ready_idx];
        ALU_BTB_pred <= btb_pred_arr[RS_ready_idx];
      end
    end
  end

`ifdef RS_PERF_EN
  // Issue and full-cycle counters; they wrap and survive a flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_issue_cnt <= '0;
      perf_full_cnt  <= '0;
    end else begin
      if (issue_en)        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (RS_full && rdy)  perf_full_cnt  <= perf_full_cnt + 32'd1;
    end
  end
`endif

  // Dispatch must stall while the station is full.
  assert property (@(posedge clk) disable iff (!rst)
                   (rdy && !ROB_clear && Dis_flag) |-> !RS_full);

endmodule
